bomb_sequencer: RTL
===================

Name: bomb_sequencer

Overview:
- Sequences the dynamite mechanic for one level. Each press of the fire key places a bomb at the hero's position, runs the fuse, and fires the blast.
- During the blast it breaks breakable walls in range and flags hero death.
- Drives bomb_pos_x/y and b_cnt into the level renderer/collision block. Feeds bw_broken back so broken walls stop drawing and colliding.

Parameters:
- TICK_DIV, 25000000: clk cycles per fuse tick (0.5 s at 50 MHz).
- FUSE_TICKS, 3: ticks from placement to blast; b_cnt value during blast.
- BLAST_TICKS, 2: ticks the blast stays active.
- BOMB_SIZE, 10: bomb half-size in pixels.
- BLAST_RANGE, 20: extra reach beyond the bomb edge, in pixels.
- CHAR_SX, 13 / CHAR_SY, 28: hero half-width / half-height in pixels.
- NUM_BW, 2: number of breakable walls.

Ports:
- clk in 1: system clock.
- reset_n in 1: asynchronous, active-low reset.
- enable in 1: level active; low aborts any bomb.
- level_restart in 1: synchronous one-cycle clear of the sticky flags.
- f_key in 1: fire key, active-high, already synchronised to clk.
- char_pos_x in 10: hero centre column.
- char_pos_y in 10: hero centre row.
- bw_l, bw_r, bw_u, bw_d in 10*NUM_BW each: breakable wall bounds, wall i in bits [10i+9:10i].
- bomb_pos_x, bomb_pos_y out 10: latched bomb centre.
- b_cnt out 4: 0 idle, 1..FUSE_TICKS-1 fuse, FUSE_TICKS blast.
- bomb_visible out 1: high in FUSE.
- blast_active out 1: high in BLAST.
- bw_broken out NUM_BW: sticky per-wall broken flags.
- death out 1: sticky hero-killed flag.
- busy out 1: state != IDLE.

Behaviour:
- Reset (reset_n low, async): state IDLE; every output 0; tick counter 0; f_prev 0.
- press = f_key & ~f_prev. f_prev updates every cycle, so a held key fires once.
- Tick counter:
  - Runs only in FUSE and BLAST.
  - Cleared on every state entry.
  - tick pulses when it reaches TICK_DIV-1, then wraps to 0.
- IDLE:
  - Condition: enable & press & ~death.
  - Effect: latch bomb_pos = char_pos; b_cnt=1; go to FUSE. Outputs update on the next edge (1-cycle latency).
- FUSE:
  - On tick: b_cnt++.
  - On the tick where b_cnt == FUSE_TICKS-1: b_cnt=FUSE_TICKS and go to BLAST.
  - Presses are ignored (one bomb at a time).
- BLAST:
  - Blast box = bomb_pos ± (BOMB_SIZE+BLAST_RANGE), computed in 11-bit.
  - Low edges saturate at 0; high edges saturate at 639 (x) and 479 (y).
  - On the first BLAST cycle only, for each i with bw_broken[i]=0: set bw_broken[i] if the blast box overlaps wall i. Overlap is inclusive: box_l<=bw_r, box_r>=bw_l, box_u<=bw_d, box_d>=bw_u.
  - On every BLAST cycle: set death if the hero box (char_pos ± CHAR_SX/CHAR_SY) overlaps the blast box (same rule).
  - After BLAST_TICKS ticks: b_cnt=0, go to IDLE.
- bw_broken and death are sticky. They clear only on reset_n or level_restart.
  - level_restart also forces IDLE and b_cnt=0.
  - level_restart has priority over all other events in that cycle.
- enable low in any state: next cycle IDLE, b_cnt=0, bomb_visible=0, blast_active=0. Sticky flags are kept. A press in the same cycle enable falls is ignored.
- A blast evaluation and a level_restart in the same cycle: the restart wins and the flags end at 0.
- death high: new bombs are blocked. A bomb already in progress completes.
- Saturation: a bomb at x=5 gives box_l=0, with no underflow wrap.

Test Plan:
- TICK_DIV=4, FUSE_TICKS=3, BLAST_TICKS=2. Place hero (100,400), wall0 at 215..250 x 125..250, press f_key 1 cycle -> next cycle bomb_pos=(100,400), b_cnt=1. b_cnt=2 after 4 cycles, 3 after 8. blast_active for 8 cycles, then b_cnt=0. bw_broken=0; death=1 since the hero overlaps.
- Hero (200,150), press, move hero to (400,440) during the fuse -> wall0 overlap (box 170..230 x 120..180) gives bw_broken[0]=1 on the first BLAST cycle. death stays 0.
- Hold f_key high for 40 cycles from IDLE -> exactly one bomb. A second press during FUSE -> no effect on b_cnt or bomb_pos.
- Drop enable mid-FUSE at b_cnt=2 -> next cycle b_cnt=0, busy=0. A previously set bw_broken stays 1.
- Assert reset_n low mid-BLAST, asynchronously between edges -> all outputs 0 immediately, without waiting for a clk edge.
- Assert level_restart on the first BLAST cycle with wall0 in range -> bw_broken=0, state IDLE, death=0.

Source files
------------

// File: rtl/bomb_sequencer.sv
// Dynamite sequencer for one level: place bomb, run fuse, fire blast.
// The blast breaks breakable walls in reach and flags hero death; both flags are sticky.
module bomb_sequencer #(
    parameter int TICK_DIV    = 25000000,
    parameter int FUSE_TICKS  = 3,
    parameter int BLAST_TICKS = 2,
    parameter int BOMB_SIZE   = 10,
    parameter int BLAST_RANGE = 20,
    parameter int CHAR_SX     = 13,
    parameter int CHAR_SY     = 28,
    parameter int NUM_BW      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  level_restart,
    input  logic                  f_key,
    input  logic [9:0]            char_pos_x,
    input  logic [9:0]            char_pos_y,
    input  logic [10*NUM_BW-1:0]  bw_l,
    input  logic [10*NUM_BW-1:0]  bw_r,
    input  logic [10*NUM_BW-1:0]  bw_u,
    input  logic [10*NUM_BW-1:0]  bw_d,
    output logic [9:0]            bomb_pos_x,
    output logic [9:0]            bomb_pos_y,
    output logic [3:0]            b_cnt,
    output logic                  bomb_visible,
    output logic                  blast_active,
    output logic [NUM_BW-1:0]     bw_broken,
    output logic                  death,
    output logic                  busy
);

    // state | meaning
    // IDLE  | no bomb; waiting for a fresh fire press
    // FUSE  | bomb placed and visible, fuse ticking
    // BLAST | blast live; walls evaluated on first cycle, hero every cycle
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FUSE  = 2'd1;
    localparam logic [1:0] BLAST = 2'd2;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [10:0] REACH = 11'(BOMB_SIZE + BLAST_RANGE);

    logic [1:0]        state;
    logic [TW-1:0]     tick_cnt;
    logic [7:0]        blast_left;
    logic              first_blast;
    logic              f_prev;
    logic              press;
    logic              tick;
    logic [10:0]       box_l, box_r, box_u, box_d;
    logic [10:0]       hero_l, hero_r, hero_u, hero_d;
    logic              hero_hit;
    logic [NUM_BW-1:0] wall_hit;

    function automatic logic [10:0] sat_lo(input logic [9:0] c, input logic [10:0] r);
        return ({1'b0, c} >= r) ? ({1'b0, c} - r) : 11'd0;
    endfunction

    function automatic logic [10:0] sat_hi(input logic [9:0] c, input logic [10:0] r,
                                           input logic [10:0] lim);
        logic [10:0] s;
        s = {1'b0, c} + r;
        return (s > lim) ? lim : s;
    endfunction

    assign press        = f_key & ~f_prev;
    assign tick         = (state != IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
    assign bomb_visible = (state == FUSE);
    assign blast_active = (state == BLAST);
    assign busy         = (state != IDLE);

    // Boxes are 11-bit so low edges can clamp at 0 instead of wrapping.
    always_comb begin
        box_l    = sat_lo(bomb_pos_x, REACH);
        box_r    = sat_hi(bomb_pos_x, REACH, 11'd639);
        box_u    = sat_lo(bomb_pos_y, REACH);
        box_d    = sat_hi(bomb_pos_y, REACH, 11'd479);
        hero_l   = sat_lo(char_pos_x, 11'(CHAR_SX));
        hero_r   = {1'b0, char_pos_x} + 11'(CHAR_SX);
        hero_u   = sat_lo(char_pos_y, 11'(CHAR_SY));
        hero_d   = {1'b0, char_pos_y} + 11'(CHAR_SY);
        hero_hit = (hero_l <= box_r) && (hero_r >= box_l) &&
                   (hero_u <= box_d) && (hero_d >= box_u);
        wall_hit = '0;
        for (int i = 0; i < NUM_BW; i++) begin
            wall_hit[i] = (box_l <= {1'b0, bw_r[10*i +: 10]}) &&
                          (box_r >= {1'b0, bw_l[10*i +: 10]}) &&
                          (box_u <= {1'b0, bw_d[10*i +: 10]}) &&
                          (box_d >= {1'b0, bw_u[10*i +: 10]});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            blast_left  <= '0;
            first_blast <= 1'b0;
            f_prev      <= 1'b0;
            bomb_pos_x  <= '0;
            bomb_pos_y  <= '0;
            b_cnt       <= '0;
            bw_broken   <= '0;
            death       <= 1'b0;
        end else begin
            f_prev <= f_key;
            if (level_restart) begin
                state       <= IDLE;
                tick_cnt    <= '0;
                first_blast <= 1'b0;
                b_cnt       <= '0;
                bw_broken   <= '0;
                death       <= 1'b0;
            end else if (!enable) begin
                state       <= IDLE;
                tick_cnt    <= '0;
                first_blast <= 1'b0;
                b_cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press && !death) begin
                            bomb_pos_x <= char_pos_x;
                            bomb_pos_y <= char_pos_y;
                            b_cnt      <= 4'd1;
                            tick_cnt   <= '0;
                            state      <= FUSE;
                        end
                    end
                    FUSE: begin
                        tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
                        if (tick) begin
                            if (b_cnt == 4'(FUSE_TICKS - 1)) begin
                                b_cnt       <= 4'(FUSE_TICKS);
                                blast_left  <= 8'(BLAST_TICKS - 1);
                                first_blast <= 1'b1;
                                state       <= BLAST;
                            end else begin
                                b_cnt <= b_cnt + 4'd1;
                            end
                        end
                    end
                    BLAST: begin
                        first_blast <= 1'b0;
                        tick_cnt    <= tick ? '0 : tick_cnt + TW'(1);
                        if (first_blast)
                            bw_broken <= bw_broken | wall_hit;
                        if (hero_hit)
                            death <= 1'b1;
                        if (tick) begin
                            if (blast_left == 8'd0) begin
                                b_cnt <= '0;
                                state <= IDLE;
                            end else begin
                                blast_left <= blast_left - 8'd1;
                            end
                        end
                    end
                    default: begin
                        b_cnt <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
